// File: rtl/snn_lif_layer.sv
// Purpose   : layer of N_OUT leaky integrate-and-fire neurons fed by N_IN rate-encoded channels.
// Latency   : step sampled at edge t -> done high in cycle t+N_OUT+2; next step accepted the cycle after.
// Backpressure: none; step is dropped while busy, weight writes are accepted in any state.
//
// Ports
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   step              start-timestep pulse, only honoured in IDLE
//   in_value          channel i intensity in bits [i*VAL_W +: VAL_W]
//   w_we/w_addr/w_data weight write port, index = k*N_IN + i (neuron k, input i)
//   in_spikes         encoder spikes of the current or last timestep
//   out_spikes        neuron spikes of the last completed timestep
//   busy, done        timestep in progress / one-cycle pulse as out_spikes updates
module snn_lif_layer #(
   parameter int N_IN       = 8,
   parameter int N_OUT      = 2,
   parameter int VAL_W      = 8,
   parameter int W_W        = 4,
   parameter int V_W        = 12,
   parameter int THRESH     = 64,
   parameter int LEAK_SHIFT = 3,
   parameter int REFRAC     = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          step,
   input  logic [N_IN*VAL_W-1:0]         in_value,
   input  logic                          w_we,
   input  logic [$clog2(N_IN*N_OUT)-1:0] w_addr,
   input  logic signed [W_W-1:0]         w_data,
   output logic [N_IN-1:0]               in_spikes,
   output logic [N_OUT-1:0]              out_spikes,
   output logic                          busy,
   output logic                          done
);

   localparam int N_W = N_IN * N_OUT;
   localparam int AW  = $clog2(N_W);
   localparam int KW  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam int RW  = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
   // Synaptic sum width: N_IN terms of a W_W-bit signed weight, plus one guard bit.
   localparam int S_W = W_W + $clog2(N_IN) + 1;
   // Membrane update is evaluated wide enough that it can never wrap before saturation.
   localparam int E_W = V_W + S_W + 1;

   localparam logic signed [E_W-1:0] V_MAX  = E_W'((2 ** (V_W - 1)) - 1);
   localparam logic signed [E_W-1:0] V_MIN  = E_W'(-(2 ** (V_W - 1)));
   localparam logic signed [V_W-1:0] THR_V  = V_W'(THRESH);
   localparam logic [RW-1:0]         REF_V  = RW'(REFRAC);
   localparam logic [KW-1:0]         K_LAST = KW'(N_OUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ENC,
      S_NEUR,
      S_DONE
   } state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [KW-1:0]           k_idx;
   logic [VAL_W-1:0]        acc        [N_IN];
   logic signed [W_W-1:0]   w_mem      [N_W];
   logic signed [V_W-1:0]   v_mem      [N_OUT];
   logic [RW-1:0]           refrac_mem [N_OUT];
   logic [N_OUT-1:0]        spike_vec;

   logic                    addr_ok;
   logic [AW-1:0]           rd_idx;
   logic signed [S_W-1:0]   syn_sum;
   logic signed [E_W-1:0]   v_ext;
   logic signed [E_W-1:0]   v_raw;
   logic signed [V_W-1:0]   v_sat;
   logic                    fire;

   // When the weight count is a power of two every address is valid.
   if (N_W == (2 ** AW)) begin : g_addr_full
      assign addr_ok = 1'b1;
   end else begin : g_addr_part
      assign addr_ok = (32'(w_addr) < N_W);
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (step) state_nxt = S_ENC;
         end
         S_ENC:  state_nxt = S_NEUR;
         S_NEUR: if (k_idx == K_LAST) state_nxt = S_DONE;
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // ---------------- neuron k datapath ----------------
   // Weights are read combinationally, so a same-cycle write is seen only from the next cycle.
   always_comb begin
      syn_sum = '0;
      rd_idx  = '0;
      for (int i = 0; i < N_IN; i++) begin
         rd_idx = AW'(int'(k_idx) * N_IN + i);
         if (in_spikes[i]) syn_sum = syn_sum + S_W'(w_mem[rd_idx]);
      end
   end

   always_comb begin
      v_ext = E_W'(v_mem[k_idx]);
      // >>> rounds toward -inf, so negative potentials also decay toward 0.
      v_raw = v_ext - (v_ext >>> LEAK_SHIFT) + E_W'(syn_sum);
      v_sat = v_raw[V_W-1:0];
      if (v_raw > V_MAX) begin
         v_sat = V_MAX[V_W-1:0];
      end else if (v_raw < V_MIN) begin
         v_sat = V_MIN[V_W-1:0];
      end
      fire = (v_sat >= THR_V);
   end

   // ---------------- state update ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         k_idx      <= '0;
         in_spikes  <= '0;
         out_spikes <= '0;
         spike_vec  <= '0;
         for (int i = 0; i < N_IN; i++) acc[i] <= '0;
         for (int j = 0; j < N_W; j++) w_mem[j] <= '0;
         for (int k = 0; k < N_OUT; k++) begin
            v_mem[k]      <= '0;
            refrac_mem[k] <= '0;
         end
      end else begin
         if (w_we && addr_ok) w_mem[w_addr] <= w_data;

         case (state)
            S_ENC: begin
               // First-order sigma-delta: the accumulator carry is the spike.
               for (int i = 0; i < N_IN; i++) begin
                  {in_spikes[i], acc[i]} <= {1'b0, acc[i]} + {1'b0, in_value[i*VAL_W +: VAL_W]};
               end
               k_idx <= '0;
            end
            S_NEUR: begin
               if (refrac_mem[k_idx] != '0) begin
                  v_mem[k_idx]      <= '0;
                  refrac_mem[k_idx] <= refrac_mem[k_idx] - 1'b1;
                  spike_vec[k_idx]  <= 1'b0;
               end else if (fire) begin
                  v_mem[k_idx]      <= '0;
                  refrac_mem[k_idx] <= REF_V;
                  spike_vec[k_idx]  <= 1'b1;
               end else begin
                  v_mem[k_idx]      <= v_sat;
                  spike_vec[k_idx]  <= 1'b0;
               end
               k_idx <= (k_idx == K_LAST) ? '0 : k_idx + 1'b1;
            end
            S_DONE: out_spikes <= spike_vec;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_snn_lif_layer.sv
// Purpose   : directed self-checking bench for snn_lif_layer with default parameters.
// Latency   : each timestep is driven as a fixed 5-cycle sequence and timing is checked exactly.
// Backpressure: not applicable; the bench drives step/weight writes directly.
module tb_snn_lif_layer;
    localparam int N_IN  = 8;
    localparam int N_OUT = 2;
    localparam int VAL_W = 8;
    localparam int W_W   = 4;
    localparam int AW    = 4;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   step;
    logic [N_IN*VAL_W-1:0]  in_value;
    logic                   w_we;
    logic [AW-1:0]          w_addr;
    logic signed [W_W-1:0]  w_data;
    logic [N_IN-1:0]        in_spikes;
    logic [N_OUT-1:0]       out_spikes;
    logic                   busy;
    logic                   done;

    int n_tests = 0;
    int n_fail  = 0;

    // Neuron 0 with +7 on ch0 and ch1: first timestep has no encoder spikes,
    // then v = 14, 27, 38, 48, 56, 63, fires at 70, two silent held steps, 14.
    logic [1:0] exp_spk3 [11] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                                  2'b01, 2'b00, 2'b00, 2'b00};
    int         exp_v3   [11] = '{0, 14, 27, 38, 48, 56, 63, 0, 0, 0, 14};

    always #5 clk = ~clk;

    snn_lif_layer dut (
        .clk        (clk),
        .reset      (reset),
        .step       (step),
        .in_value   (in_value),
        .w_we       (w_we),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .in_spikes  (in_spikes),
        .out_spikes (out_spikes),
        .busy       (busy),
        .done       (done)
    );

    task automatic chk(input string tag, input bit ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $error("FAIL %s", tag);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic wr_w(input int k, input int i, input int val);
        w_we   = 1'b1;
        w_addr = AW'(k * N_IN + i);
        w_data = W_W'(val);
        @(negedge clk);
        w_we   = 1'b0;
    endtask

    // One timestep from IDLE; optionally writes a weight during the NEUR k=0 cycle.
    task automatic run_step(input logic mid_wr, input int wr_addr, input int wr_val);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        chk("enc_busy", busy === 1'b1);
        chk("enc_done", done === 1'b0);
        @(negedge clk);
        if (mid_wr) begin
            w_we   = 1'b1;
            w_addr = AW'(wr_addr);
            w_data = W_W'(wr_val);
        end
        @(negedge clk);
        w_we = 1'b0;
        chk("n1_done", done === 1'b0);
        @(negedge clk);
        chk("done_pulse", done === 1'b1);
        @(negedge clk);
        chk("idle_busy", busy === 1'b0);
        chk("idle_done", done === 1'b0);
    endtask

    function automatic int count_nz_w();
        int nz = 0;
        for (int j = 0; j < N_IN * N_OUT; j++) if (dut.w_mem[AW'(j)] != '0) nz++;
        return nz;
    endfunction

    function automatic int count_nz_acc();
        int nz = 0;
        for (int j = 0; j < N_IN; j++) if (dut.acc[3'(j)] != '0) nz++;
        return nz;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt0, cnt1, cnt_oth, done_cnt;
        int d_at [$];

        reset    = 1'b1;
        step     = 1'b0;
        in_value = '0;
        w_we     = 1'b0;
        w_addr   = '0;
        w_data   = '0;

        // ---- T1: reset holds everything at zero despite write/step activity ----
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            step     = 1'b1;
            w_we     = 1'($urandom_range(0, 1));
            w_addr   = AW'($urandom_range(0, 15));
            w_data   = W_W'($urandom_range(1, 15));
            in_value = {$urandom, $urandom};
        end
        @(negedge clk);
        chk("t1_in_spikes", in_spikes === 8'h00);
        chk("t1_out_spikes", out_spikes === 2'b00);
        chk("t1_busy", busy === 1'b0);
        chk("t1_done", done === 1'b0);
        chk("t1_weights_zero", count_nz_w() == 0);
        step     = 1'b0;
        w_we     = 1'b0;
        in_value = '0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_step(1'b0, 0, 0);
        chk("t1_out_after_step", out_spikes === 2'b00);

        // ---- T2: encoder rates over 256 timesteps ----
        in_value = '0;
        in_value[0*VAL_W +: VAL_W] = 8'd128;
        in_value[1*VAL_W +: VAL_W] = 8'd255;
        cnt0 = 0; cnt1 = 0; cnt_oth = 0;
        for (int s = 0; s < 256; s++) begin
            run_step(1'b0, 0, 0);
            cnt0    += int'(in_spikes[0]);
            cnt1    += int'(in_spikes[1]);
            cnt_oth += $countones(in_spikes[7:2]);
        end
        chk("t2_ch0_count", cnt0 == 128);
        chk("t2_ch1_count", cnt1 == 255);
        chk("t2_other_count", cnt_oth == 0);

        // ---- T3: integrate, fire, refractory hold ----
        do_reset();
        wr_w(0, 0, 7);
        wr_w(0, 1, 7);
        in_value = '0;
        in_value[0*VAL_W +: VAL_W] = 8'd255;
        in_value[1*VAL_W +: VAL_W] = 8'd255;
        for (int s = 0; s < 11; s++) begin
            run_step(1'b0, 0, 0);
            chk("t3_out_spikes", out_spikes === exp_spk3[s]);
            chk("t3_v0", int'(dut.v_mem[0]) == exp_v3[s]);
            if (s == 1) chk("t3_in_spikes", in_spikes === 8'h03);
        end

        // ---- T4: strong inhibition, leak-limited negative potential ----
        do_reset();
        for (int i = 0; i < N_IN; i++) wr_w(1, i, -8);
        in_value = {N_IN{8'd255}};
        for (int s = 0; s < 40; s++) begin
            run_step(1'b0, 0, 0);
            chk("t4_no_spike", out_spikes === 2'b00);
            chk("t4_nonpos", int'(dut.v_mem[1]) <= 0);
            if (s == 1) chk("t4_v1_step2", int'(dut.v_mem[1]) == -64);
            if (s == 4) chk("t4_v1_step5", int'(dut.v_mem[1]) == -211);
        end
        chk("t4_v1_steady", int'(dut.v_mem[1]) == -505);
        chk("t4_v0_idle", int'(dut.v_mem[0]) == 0);

        // ---- T5: step held high, then mid-sweep weight writes ----
        do_reset();
        in_value = '0;
        in_value[0*VAL_W +: VAL_W] = 8'd255;
        step = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (done) d_at.push_back(c);
        end
        step = 1'b0;
        repeat (4) @(negedge clk);
        chk("t5_done_count", d_at.size() == 3);
        chk("t5_done_first", d_at[0] == 4);
        chk("t5_done_second", d_at[1] == 9);
        chk("t5_done_third", d_at[2] == 14);
        chk("t5_idle_after", busy === 1'b0);
        // w[1][0] written during NEUR k=0: neuron 1 uses it in the same timestep.
        run_step(1'b1, 1 * N_IN + 0, 5);
        chk("t5_v1_new_weight", int'(dut.v_mem[1]) == 5);
        chk("t5_v0_untouched", int'(dut.v_mem[0]) == 0);
        // w[0][0] written during NEUR k=0: neuron 0 still reads the old value.
        run_step(1'b1, 0 * N_IN + 0, 3);
        chk("t5_v0_old_weight", int'(dut.v_mem[0]) == 0);
        chk("t5_v1_second", int'(dut.v_mem[1]) == 10);
        run_step(1'b0, 0, 0);
        chk("t5_v0_new_weight", int'(dut.v_mem[0]) == 3);
        chk("t5_v1_third", int'(dut.v_mem[1]) == 14);

        // ---- T6: reset asserted during NEUR aborts the timestep ----
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t6_busy_now", busy === 1'b0);
        chk("t6_done_now", done === 1'b0);
        @(negedge clk);
        reset = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("t6_no_done", done_cnt == 0);
        chk("t6_busy", busy === 1'b0);
        chk("t6_in_spikes", in_spikes === 8'h00);
        chk("t6_out_spikes", out_spikes === 2'b00);
        chk("t6_v0", int'(dut.v_mem[0]) == 0);
        chk("t6_v1", int'(dut.v_mem[1]) == 0);
        chk("t6_weights", count_nz_w() == 0);
        chk("t6_acc", count_nz_acc() == 0);
        run_step(1'b0, 0, 0);
        chk("t6_restart_out", out_spikes === 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
